// File: rtl/result_wb_master.sv
// Write-back master: captures one POY x POX result tile and writes it to
// memory as one AXI INCR burst of POX beats per tile row.
//
// state  | meaning
// IDLE   | waiting for result_valid; tile buffer free
// AW     | presenting the row burst address (awvalid high)
// W      | streaming POX beats of the current row (wvalid high)
// B      | waiting for the write response of the current row (bready high)
module result_wb_master #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int POX   = 15,
  parameter int POY   = 3,
  parameter int BURST = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] wb_base_addr,
  input  logic [AW-1:0] row_stride,
  input  logic          result_valid,
  input  logic [DW-1:0] result [POY][POX],
  output logic          busy,
  output logic          wb_done,
  output logic          overrun,
  output logic          wr_err,
  output logic [AW-1:0] awaddr,
  output logic [7:0]    awlen,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready
);

  localparam int RW = $clog2(POY) + 1;
  localparam int BW = $clog2(POX) + 1;

  localparam logic [RW-1:0] LAST_ROW  = RW'(POY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(POX - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  generate
    if (POX < 1 || POX > BURST) begin : g_bad_pox
      $error("result_wb_master: POX must be within 1..BURST");
    end
    if (POY < 1) begin : g_bad_poy
      $error("result_wb_master: POY must be at least 1");
    end
  endgenerate

  logic [1:0]    state_q,    state_d;
  logic [RW-1:0] row_q,      row_d;
  logic [BW-1:0] beat_q,     beat_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] stride_q,   stride_d;
  logic          overrun_q,  overrun_d;
  logic          wr_err_q,   wr_err_d;
  logic          done_q,     done_d;

  logic [DW-1:0] tile_q [POY][POX];
  logic [DW-1:0] wdata_sel;
  logic          capture;

  assign capture = result_valid && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    beat_d     = beat_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    overrun_d  = overrun_q;
    wr_err_d   = wr_err_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d    = S_AW;
          row_d      = '0;
          beat_d     = '0;
          row_base_d = wb_base_addr;
          stride_d   = row_stride;
        end
      end
      S_AW: begin
        if (awready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (wready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            wr_err_d = 1'b1;
          end
          if (row_q == LAST_ROW) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            // Address arithmetic wraps modulo 2^AW by design.
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + stride_q;
            state_d    = S_AW;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Includes the cycle of the final B handshake: the tile is not yet retired.
    if (result_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      beat_q     <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      overrun_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      beat_q     <= beat_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      overrun_q  <= overrun_d;
      wr_err_q   <= wr_err_d;
      done_q     <= done_d;
    end
  end

  // Pure data storage; only ever read while a capture is in flight.
  always_ff @(posedge clk) begin
    if (capture) begin
      tile_q <= result;
    end
  end

  always_comb begin
    wdata_sel = '0;
    for (int r = 0; r < POY; r++) begin
      for (int c = 0; c < POX; c++) begin
        if ((row_q == RW'(r)) && (beat_q == BW'(c))) begin
          wdata_sel = tile_q[r][c];
        end
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign wb_done = done_q;
  assign overrun = overrun_q;
  assign wr_err  = wr_err_q;

  assign awaddr  = row_base_q;
  assign awlen   = 8'(POX - 1);
  assign awburst = 2'b01;
  assign awvalid = (state_q == S_AW);

  assign wvalid  = (state_q == S_W);
  assign wdata   = (state_q == S_W) ? wdata_sel : '0;
  assign wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);

  assign bready  = (state_q == S_B);

endmodule

// File: tb/tb_result_wb_master.sv
// Bench for result_wb_master: behavioural AXI slave with configurable stalls
// and a scoreboard of expected AW addresses and W beats.
module tb_result_wb_master;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int POX = 15;
  localparam int POY = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] wb_base_addr = '0;
  logic [AW-1:0] row_stride = '0;
  logic          result_valid = 1'b0;
  logic [DW-1:0] result [POY][POX];
  logic          busy, wb_done, overrun, wr_err;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;

  result_wb_master #(.DW(DW), .AW(AW), .POX(POX), .POY(POY), .BURST(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_base_addr(wb_base_addr), .row_stride(row_stride),
    .result_valid(result_valid), .result(result),
    .busy(busy), .wb_done(wb_done), .overrun(overrun), .wr_err(wr_err),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Slave configuration
  int aw_stall = 0;
  int b_delay  = 0;
  bit w_toggle = 1'b0;
  int err_at   = -1;

  // Scoreboard and monitor bookkeeping
  logic [AW-1:0] exp_aw [$];
  logic [DW:0]   exp_w  [$];
  logic [AW-1:0] aw_log [64];
  int aw_total = 0;
  int w_total  = 0;
  int b_total  = 0;
  int aw_out   = 0;
  bit aw_hold = 1'b0, w_hold = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW:0]   hold_w;

  initial begin
    for (int r = 0; r < POY; r++)
      for (int c = 0; c < POX; c++)
        result[r][c] = '0;
  end

  // Behavioural slave: drives ready/response right after each rising edge.
  initial begin
    int aw_cnt = 0;
    int b_cnt  = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin
        awready = (aw_cnt >= aw_stall);
        aw_cnt++;
      end else begin
        awready = 1'b0;
        aw_cnt = 0;
      end
      if (w_toggle) wready = ~wready;
      else          wready = 1'b1;
      if (bready) begin
        if (b_cnt >= b_delay) begin
          bvalid = 1'b1;
          bresp  = (b_total == err_at) ? 2'b10 : 2'b00;
        end else begin
          bvalid = 1'b0;
        end
        b_cnt++;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
        b_cnt  = 0;
      end
    end
  end

  // Monitor: samples on the falling edge what the next rising edge will accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_aw.delete();
      exp_w.delete();
      aw_out  = 0;
      aw_hold = 1'b0;
      w_hold  = 1'b0;
    end else begin
      if (aw_hold && awvalid) begin
        checks++;
        if (awaddr !== hold_addr) begin
          errors++;
          $display("FAIL aw_stable got %h want %h", awaddr, hold_addr);
        end
      end
      aw_hold   = awvalid && !awready;
      hold_addr = awaddr;
      if (w_hold && wvalid) begin
        checks++;
        if ({wlast, wdata} !== hold_w) begin
          errors++;
          $display("FAIL w_stable got %h want %h", {wlast, wdata}, hold_w);
        end
      end
      w_hold = wvalid && !wready;
      hold_w = {wlast, wdata};

      if (wvalid) begin
        checks++;
        if (aw_out != 1) begin
          errors++;
          $display("FAIL w_without_aw outstanding %0d want 1", aw_out);
        end
      end
      if (awvalid) begin
        checks++;
        if (aw_out != 0) begin
          errors++;
          $display("FAIL aw_while_outstanding outstanding %0d want 0", aw_out);
        end
      end

      if (awvalid && awready) begin
        aw_log[aw_total % 64] = awaddr;
        aw_total++;
        aw_out++;
        checks++;
        if (exp_aw.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected got %h want none", awaddr);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_aw.pop_front();
          if (awaddr !== ea || awlen !== 8'd14 || awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw_beat got %h/%0d/%0d want %h/14/1", awaddr, awlen, awburst, ea);
          end
        end
      end
      if (wvalid && wready) begin
        w_total++;
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected got %h want none", {wlast, wdata});
        end else begin
          logic [DW:0] ew;
          ew = exp_w.pop_front();
          if ({wlast, wdata} !== ew) begin
            errors++;
            $display("FAIL w_beat got %h want %h", {wlast, wdata}, ew);
          end
        end
        if (wlast) aw_out--;
      end
      if (bvalid && bready) b_total++;
    end
  end

  // Drives one capture pulse; leaves the caller #1 after the capture edge.
  task automatic start_tile(input int seed, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride, input bit expect_it);
    for (int r = 0; r < POY; r++)
      for (int c = 0; c < POX; c++)
        result[r][c] = DW'(seed + r * 100 + c);
    wb_base_addr = base;
    row_stride   = stride;
    if (expect_it) begin
      for (int r = 0; r < POY; r++) begin
        logic [AW-1:0] a;
        a = base + stride * AW'(r);
        exp_aw.push_back(a);
        for (int c = 0; c < POX; c++)
          exp_w.push_back({(c == POX - 1), DW'(seed + r * 100 + c)});
      end
    end
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (wb_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, wb_done, overrun, wr_err, awvalid, wvalid, wlast, bready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000",
               {busy, wb_done, overrun, wr_err, awvalid, wvalid, wlast, bready});
    end
    checks++;
    if (awaddr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_buses got %h/%h want 0/0", awaddr, wdata);
    end
    checks++;
    if (awlen !== 8'd14 || awburst !== 2'b01) begin
      errors++;
      $display("FAIL reset_consts got %0d/%0d want 14/1", awlen, awburst);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int t0;
    start_tile(0, 32'h100, 32'd32, 1'b1);
    checks++;
    if (busy !== 1'b1 || awvalid !== 1'b1 || awaddr !== 32'h100) begin
      errors++;
      $display("FAIL first_aw got busy %b awvalid %b addr %h want 1 1 100", busy, awvalid, awaddr);
    end
    t0 = cyc;
    wait_done(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done_timeout got none want wb_done");
    end
    checks++;
    if (cyc - t0 != 51) begin
      errors++;
      $display("FAIL basic_latency got %0d want 51", cyc - t0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall got %b want 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b want 0", wb_done);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL basic_drain got %0d/%0d want 0/0", exp_aw.size(), exp_w.size());
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    aw_stall = 4; w_toggle = 1'b1; b_delay = 5;
    start_tile(0, 32'h100, 32'd32, 1'b1);
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_done_timeout got none want wb_done");
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d/%0d want 0/0", exp_aw.size(), exp_w.size());
    end
    aw_stall = 0; w_toggle = 1'b0; b_delay = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_overrun;
    bit ok;
    int a0 = aw_total;
    int n = 0;
    start_tile(7, 32'h400, 32'd16, 1'b1);
    while (aw_total < a0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (aw_total < a0 + 2) begin
      errors++;
      $display("FAIL ovr_row1_timeout got %0d bursts want 2", aw_total - a0);
    end
    start_tile(5000, 32'h900, 32'd64, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    wait_done(300, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_finish got done %b busy %b want 1 0", ok, busy);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL ovr_drain got %0d/%0d want 0/0", exp_aw.size(), exp_w.size());
    end
  endtask

  task automatic test_error;
    bit ok;
    err_at = b_total + 1;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", wr_err);
    end
    start_tile(300, 32'h800, 32'd20, 1'b1);
    wait_done(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL err_done_timeout got none want wb_done");
    end
    checks++;
    if (wr_err !== 1'b1 || exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL err_result got wr_err %b left %0d want 1 0", wr_err, exp_aw.size());
    end
    err_at = -1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_err !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL sticky got wr_err %b overrun %b want 1 1", wr_err, overrun);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w0 = w_total;
    int a0;
    int n = 0;
    start_tile(11, 32'h600, 32'd32, 1'b1);
    while (w_total < w0 + 22 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (w_total != w0 + 22 || wvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach got %0d beats want 22", w_total - w0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, wlast, bready, busy, overrun, wr_err} !== 7'b0 || wdata !== '0) begin
      errors++;
      $display("FAIL async_reset got %b/%h want 0000000/0",
               {awvalid, wvalid, wlast, bready, busy, overrun, wr_err}, wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a0 = aw_total;
    start_tile(40, 32'h200, 32'd32, 1'b1);
    wait_done(300, ok);
    checks++;
    if (!ok || aw_log[a0 % 64] !== 32'h200) begin
      errors++;
      $display("FAIL post_reset got done %b addr %h want 1 200", ok, aw_log[a0 % 64]);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL post_reset_drain got %0d/%0d want 0/0", exp_aw.size(), exp_w.size());
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int a0 = aw_total;
    start_tile(900, 32'hFFFF_FFF0, 32'h10, 1'b1);
    wait_done(300, ok);
    checks++;
    if (!ok || aw_log[(a0 + 1) % 64] !== 32'h0 || aw_log[(a0 + 2) % 64] !== 32'h10) begin
      errors++;
      $display("FAIL wrap got %h %h want 00000000 00000010",
               aw_log[(a0 + 1) % 64], aw_log[(a0 + 2) % 64]);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain got %0d/%0d want 0/0", exp_aw.size(), exp_w.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_error();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
